operand_fetch: RTL and testbench

- Issue stage between decode and execute.
- Drives both register_file read ports and tracks in-flight destination registers in a per-register busy scoreboard.
- Stalls decode on RAW/WAW hazards and forwards the same-cycle writeback value, which register_file only makes visible after the clock edge.
- Registers the issued instruction into a valid/ready pipeline register toward execute.

---
 rtl/riscv_cpu_pkg.sv | 27 ++
 rtl/operand_scoreboard.sv | 60 ++++++
 rtl/operand_fetch.sv | 112 +++++++++++
 tb/tb_operand_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared widths, the issue packet carried from operand fetch to execute,
// and the writeback forwarding predicate.
package riscv_cpu_pkg;

  localparam int unsigned ADDR_WIDTH       = 5;
  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned NUM_REGS         = 2 ** ADDR_WIDTH;
  localparam int unsigned OP_WIDTH_DEFAULT = 8;

  typedef struct packed {
    logic [OP_WIDTH_DEFAULT-1:0] op;
    logic [DATA_WIDTH-1:0]       rs1_data;
    logic [DATA_WIDTH-1:0]       rs2_data;
    logic [DATA_WIDTH-1:0]       imm;
    logic [ADDR_WIDTH-1:0]       rd;
    logic                        rd_we;
  } issue_pkt_t;

  // Writeback lands in the register file only after the edge, so a same-cycle
  // write to a source must be bypassed; x0 is never bypassed.
  function automatic logic fwd_hit(input logic                  we,
                                   input logic [ADDR_WIDTH-1:0] waddr,
                                   input logic [ADDR_WIDTH-1:0] src);
    return we && (waddr == src) && (src != '0);
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight destinations and flags
// RAW/WAW hazards for the instruction currently offered by decode.
module operand_scoreboard
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic                  rd_we_i,
  input  logic                  issue_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  output logic                  fwd_a_c,
  output logic                  fwd_b_c,
  output logic                  hazard_c
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                raw_a;
  logic                raw_b;
  logic                waw;

  assign fwd_a_c = fwd_hit(wb_we_i, wb_waddr_i, rs1_i);
  assign fwd_b_c = fwd_hit(wb_we_i, wb_waddr_i, rs2_i);

  // A source waiting on a busy register is satisfied by a same-cycle writeback.
  assign raw_a    = use_rs1_i && (rs1_i != '0) && busy_q[rs1_i] && !fwd_a_c;
  assign raw_b    = use_rs2_i && (rs2_i != '0) && busy_q[rs2_i] && !fwd_b_c;
  assign waw      = rd_we_i && (rd_i != '0) && busy_q[rd_i] &&
                    !(wb_we_i && (wb_waddr_i == rd_i));
  assign hazard_c = raw_a || raw_b || waw;

  // Clear before set so a retiring and a newly issued writer of the same
  // register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_we_i) begin
      busy_d[wb_waddr_i] = 1'b0;
    end
    if (issue_i && rd_we_i && (rd_i != '0)) begin
      busy_d[rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands, resolves hazards against the scoreboard,
// bypasses writeback and registers the issued instruction toward execute.
module operand_fetch
  import riscv_cpu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = OP_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [OP_WIDTH-1:0]   dec_op_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic [ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic                  dec_use_rs1_i,
  input  logic                  dec_use_rs2_i,
  input  logic [ADDR_WIDTH-1:0] dec_rd_i,
  input  logic                  dec_rd_we_i,
  input  logic [DATA_WIDTH-1:0] dec_imm_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [OP_WIDTH-1:0]   ex_op_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [ADDR_WIDTH-1:0] ex_rd_o,
  output logic                  ex_rd_we_o
);

  logic       fwd_a;
  logic       fwd_b;
  logic       hazard;
  logic       issue;
  logic       ex_valid_q;
  issue_pkt_t ex_q;
  issue_pkt_t issue_d;

  assign rf_raddr_a_o = dec_rs1_i;
  assign rf_raddr_b_o = dec_rs2_i;

  operand_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .rs1_i      (dec_rs1_i),
    .rs2_i      (dec_rs2_i),
    .use_rs1_i  (dec_use_rs1_i),
    .use_rs2_i  (dec_use_rs2_i),
    .rd_i       (dec_rd_i),
    .rd_we_i    (dec_rd_we_i),
    .issue_i    (issue),
    .wb_we_i    (wb_we_i),
    .wb_waddr_i (wb_waddr_i),
    .fwd_a_c    (fwd_a),
    .fwd_b_c    (fwd_b),
    .hazard_c   (hazard)
  );

  // Ready never looks at dec_valid_i, so decode may wait on it.
  assign dec_ready_o = !rst_i && !flush_i && !hazard && (!ex_valid_q || ex_ready_i);
  assign issue       = dec_valid_i && dec_ready_o;

  always_comb begin
    issue_d          = '0;
    issue_d.op       = OP_WIDTH_DEFAULT'(dec_op_i);
    issue_d.imm      = dec_imm_i;
    issue_d.rd       = dec_rd_i;
    issue_d.rd_we    = dec_rd_we_i;
    if (fwd_a) begin
      issue_d.rs1_data = wb_wdata_i;
    end else if (dec_rs1_i != '0) begin
      issue_d.rs1_data = rf_rdata_a_i;
    end
    if (fwd_b) begin
      issue_d.rs2_data = wb_wdata_i;
    end else if (dec_rs2_i != '0) begin
      issue_d.rs2_data = rf_rdata_b_i;
    end
  end

  // Output register holds its contents whenever execute stalls it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      ex_q       <= issue_d;
    end else if (ex_ready_i) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_op_o       = OP_WIDTH'(ex_q.op);
  assign ex_rs1_data_o = ex_q.rs1_data;
  assign ex_rs2_data_o = ex_q.rs2_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rd_o       = ex_q.rd;
  assign ex_rd_we_o    = ex_q.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, issue, forwarding, WAW,
// backpressure, x0 handling and flush, checked with immediate assertions.
module tb_operand_fetch;
  import riscv_cpu_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  flush_i;
  logic                  dec_valid_i;
  logic                  dec_ready_o;
  logic [7:0]            dec_op_i;
  logic [ADDR_WIDTH-1:0] dec_rs1_i;
  logic [ADDR_WIDTH-1:0] dec_rs2_i;
  logic                  dec_use_rs1_i;
  logic                  dec_use_rs2_i;
  logic [ADDR_WIDTH-1:0] dec_rd_i;
  logic                  dec_rd_we_i;
  logic [DATA_WIDTH-1:0] dec_imm_i;
  logic [ADDR_WIDTH-1:0] rf_raddr_a_o;
  logic [DATA_WIDTH-1:0] rf_rdata_a_i;
  logic [ADDR_WIDTH-1:0] rf_raddr_b_o;
  logic [DATA_WIDTH-1:0] rf_rdata_b_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_waddr_i;
  logic [DATA_WIDTH-1:0] wb_wdata_i;
  logic                  ex_valid_o;
  logic                  ex_ready_i;
  logic [7:0]            ex_op_o;
  logic [DATA_WIDTH-1:0] ex_rs1_data_o;
  logic [DATA_WIDTH-1:0] ex_rs2_data_o;
  logic [DATA_WIDTH-1:0] ex_imm_o;
  logic [ADDR_WIDTH-1:0] ex_rd_o;
  logic                  ex_rd_we_o;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch #(.OP_WIDTH(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .dec_valid_i   (dec_valid_i),
    .dec_ready_o   (dec_ready_o),
    .dec_op_i      (dec_op_i),
    .dec_rs1_i     (dec_rs1_i),
    .dec_rs2_i     (dec_rs2_i),
    .dec_use_rs1_i (dec_use_rs1_i),
    .dec_use_rs2_i (dec_use_rs2_i),
    .dec_rd_i      (dec_rd_i),
    .dec_rd_we_i   (dec_rd_we_i),
    .dec_imm_i     (dec_imm_i),
    .rf_raddr_a_o  (rf_raddr_a_o),
    .rf_rdata_a_i  (rf_rdata_a_i),
    .rf_raddr_b_o  (rf_raddr_b_o),
    .rf_rdata_b_i  (rf_rdata_b_i),
    .wb_we_i       (wb_we_i),
    .wb_waddr_i    (wb_waddr_i),
    .wb_wdata_i    (wb_wdata_i),
    .ex_valid_o    (ex_valid_o),
    .ex_ready_i    (ex_ready_i),
    .ex_op_o       (ex_op_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rd_o       (ex_rd_o),
    .ex_rd_we_o    (ex_rd_we_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic instr(input logic [7:0] op,
                       input logic [4:0] rs1, input logic use1,
                       input logic [4:0] rs2, input logic use2,
                       input logic [4:0] rd,  input logic rdwe,
                       input logic [31:0] imm);
    dec_valid_i   = 1'b1;
    dec_op_i      = op;
    dec_rs1_i     = rs1;
    dec_use_rs1_i = use1;
    dec_rs2_i     = rs2;
    dec_use_rs2_i = use2;
    dec_rd_i      = rd;
    dec_rd_we_i   = rdwe;
    dec_imm_i     = imm;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wb_we_i    = we;
    wb_waddr_i = addr;
    wb_wdata_i = data;
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    ex_ready_i = 1'b1;
    rf_rdata_a_i = '0;
    rf_rdata_b_i = '0;
    wb(1'b0, 5'd0, 32'h0);
    instr(8'h13, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'h0);

    // Reset held two cycles with a valid instruction offered
    #1;
    chk("rst_ready", 32'(dec_ready_o), 32'h0);
    step();
    chk("rst_ready_c1", 32'(dec_ready_o), 32'h0);
    step();
    chk("rst_valid", 32'(ex_valid_o), 32'h0);
    chk("rst_op", 32'(ex_op_o), 32'h0);
    chk("rst_rs1", ex_rs1_data_o, 32'h0);
    chk("rst_imm", ex_imm_o, 32'h0);
    chk("rst_busy", dut.u_scoreboard.busy_q, 32'h0);
    rst_i = 1'b0;

    // addi x1, x0, 5
    instr(8'h13, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 32'h5);
    rf_rdata_a_i = 32'h11;
    #1;
    chk("a_ready", 32'(dec_ready_o), 32'h1);
    step();
    chk("a_valid", 32'(ex_valid_o), 32'h1);
    chk("a_op", 32'(ex_op_o), 32'h13);
    chk("a_rs1_x0", ex_rs1_data_o, 32'h0);
    chk("a_imm", ex_imm_o, 32'h5);
    chk("a_rd", 32'(ex_rd_o), 32'h1);
    chk("a_rdwe", 32'(ex_rd_we_o), 32'h1);
    chk("a_busy", dut.u_scoreboard.busy_q, 32'h0000_0002);

    // Independent reader of x2/x3 right behind
    instr(8'h33, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 32'h0);
    rf_rdata_a_i = 32'h11;
    rf_rdata_b_i = 32'h22;
    #1;
    chk("b_ready", 32'(dec_ready_o), 32'h1);
    chk("b_raddr_a", 32'(rf_raddr_a_o), 32'h2);
    chk("b_raddr_b", 32'(rf_raddr_b_o), 32'h3);
    step();
    chk("b_valid", 32'(ex_valid_o), 32'h1);
    chk("b_op", 32'(ex_op_o), 32'h33);
    chk("b_rs1", ex_rs1_data_o, 32'h11);
    chk("b_rs2", ex_rs2_data_o, 32'h22);
    chk("b_rdwe", 32'(ex_rd_we_o), 32'h0);

    // Idle cycle retires x1
    dec_valid_i = 1'b0;
    wb(1'b1, 5'd1, 32'h55);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("idle_valid", 32'(ex_valid_o), 32'h0);
    chk("x1_cleared", dut.u_scoreboard.busy_q, 32'h0);

    // RAW on x5 resolved by forwarding
    instr(8'h01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'h0);
    step();
    chk("x5_busy", dut.u_scoreboard.busy_q, 32'h0000_0020);
    instr(8'h02, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 32'h0);
    rf_rdata_a_i = 32'h99;
    #1;
    chk("raw_stall", 32'(dec_ready_o), 32'h0);
    step();
    chk("raw_bubble", 32'(ex_valid_o), 32'h0);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("raw_fwd_ready", 32'(dec_ready_o), 32'h1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("raw_valid", 32'(ex_valid_o), 32'h1);
    chk("raw_op", 32'(ex_op_o), 32'h02);
    chk("raw_fwd_data", ex_rs1_data_o, 32'hDEADBEEF);
    chk("raw_busy", dut.u_scoreboard.busy_q, 32'h0);

    // WAW on x7 with clear and set in the same cycle
    instr(8'h07, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0);
    step();
    chk("x7_busy", dut.u_scoreboard.busy_q, 32'h0000_0080);
    instr(8'h77, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0);
    #1;
    chk("waw_stall", 32'(dec_ready_o), 32'h0);
    step();
    wb(1'b1, 5'd7, 32'h7);
    #1;
    chk("waw_ready", 32'(dec_ready_o), 32'h1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("waw_op", 32'(ex_op_o), 32'h77);
    chk("waw_rd", 32'(ex_rd_o), 32'h7);
    chk("waw_busy_kept", dut.u_scoreboard.busy_q, 32'h0000_0080);
    dec_valid_i = 1'b0;
    wb(1'b1, 5'd7, 32'h8);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("x7_cleared", dut.u_scoreboard.busy_q, 32'h0);

    // Backpressure holds the output register
    instr(8'h42, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 32'h1234);
    rf_rdata_a_i = 32'h11;
    step();
    chk("bp_valid", 32'(ex_valid_o), 32'h1);
    ex_ready_i = 1'b0;
    instr(8'h43, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 32'h5678);
    rf_rdata_a_i = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(dec_ready_o), 32'h0);
      step();
      chk("bp_hold_valid", 32'(ex_valid_o), 32'h1);
      chk("bp_hold_op", 32'(ex_op_o), 32'h42);
      chk("bp_hold_rs1", ex_rs1_data_o, 32'h11);
      chk("bp_hold_imm", ex_imm_o, 32'h1234);
      chk("bp_hold_rd", 32'(ex_rd_o), 32'h8);
    end
    ex_ready_i = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(dec_ready_o), 32'h1);
    step();
    chk("bp_resume_op", 32'(ex_op_o), 32'h43);
    chk("bp_resume_rs1", ex_rs1_data_o, 32'hAA);

    // x0 destination never marks busy; x0 reads are 0 even with a write to x0
    instr(8'h50, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h0);
    step();
    chk("x0_not_busy", dut.u_scoreboard.busy_q, 32'h0);
    instr(8'h51, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0);
    rf_rdata_a_i = 32'hFFFF;
    rf_rdata_b_i = 32'hEEEE;
    wb(1'b1, 5'd0, 32'h1234);
    #1;
    chk("x0_ready", 32'(dec_ready_o), 32'h1);
    step();
    chk("x0_rs1", ex_rs1_data_o, 32'h0);
    chk("x0_rs2", ex_rs2_data_o, 32'h0);

    // Writeback to a non-busy register is still forwarded
    instr(8'h52, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    rf_rdata_a_i = 32'h5;
    wb(1'b1, 5'd9, 32'hCAFE);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("nb_fwd", ex_rs1_data_o, 32'hCAFE);
    chk("nb_busy", dut.u_scoreboard.busy_q, 32'h0);

    // Flush kills the held instruction and clears the scoreboard
    instr(8'h60, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h0);
    step();
    chk("fl_pre_busy", dut.u_scoreboard.busy_q, 32'h0000_0008);
    chk("fl_pre_valid", 32'(ex_valid_o), 32'h1);
    instr(8'h61, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'h0);
    flush_i = 1'b1;
    #1;
    chk("fl_ready", 32'(dec_ready_o), 32'h0);
    step();
    flush_i = 1'b0;
    dec_valid_i = 1'b0;
    chk("fl_valid", 32'(ex_valid_o), 32'h0);
    chk("fl_busy", dut.u_scoreboard.busy_q, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
